// File: rtl/pipeline_issue_ctrl_if.sv
// Requester/datapath-facing signals of the issue controller.
// The master side drives instructions and halt; the slave side is the controller.
interface pipeline_issue_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [2:0]       in_rd;
    logic [2:0]       in_rs1;
    logic [2:0]       in_rs2;
    logic             iss_valid;
    logic [2:0]       iss_op;
    logic [2:0]       iss_rd;
    logic [2:0]       iss_rs1;
    logic [2:0]       iss_rs2;
    logic [1:0]       fwd_sel1;
    logic [1:0]       fwd_sel2;
    logic             halt_req;
    logic             halted;
    logic [CNT_W-1:0] issue_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, halt_req,
        input  in_ready, iss_valid, iss_op, iss_rd, iss_rs1, iss_rs2,
        input  fwd_sel1, fwd_sel2, halted, issue_cnt, stall_cnt
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, halt_req,
        output in_ready, iss_valid, iss_op, iss_rd, iss_rs1, iss_rs2,
        output fwd_sel1, fwd_sel2, halted, issue_cnt, stall_cnt
    );
endinterface

// File: rtl/pipeline_issue_ctrl.sv
// Issue controller for the 3-stage pipeline: hazard scoreboard mirroring EX/WB,
// forwarding-select generation, halt/drain FSM and issue/stall counters.
module pipeline_issue_ctrl #(
    parameter int FWD_MODE = 2,
    parameter int CNT_W    = 32
) (
    input logic                 clk,
    input logic                 rst,
    pipeline_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

    state_t           state, state_nxt;
    logic             ex_v, wb_v;
    logic [2:0]       ex_rd, wb_rd;
    logic [CNT_W-1:0] issue_cnt_q, stall_cnt_q;
    logic             use1, use2;
    logic             mex1, mwb1, mex2, mwb2;
    logic             hazard, ready, issue;
    logic [1:0]       sel1, sel2;

    function automatic logic haz_of(input logic mex, input logic mwb);
        case (FWD_MODE)
            0:       return mex | mwb;
            1:       return mex;
            default: return 1'b0;
        endcase
    endfunction

    // EX is checked first: it holds the youngest producer of the register.
    function automatic logic [1:0] sel_of(input logic mex, input logic mwb);
        if (mex && FWD_MODE >= 2)
            return 2'd1;
        else if (mwb && !mex && FWD_MODE >= 1)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    // Immediates (op 7) read no registers, so they never match the scoreboard.
    assign use1 = (bus.in_op != 3'd7);
    assign use2 = (bus.in_op != 3'd7);
    assign mex1 = use1 && ex_v && (ex_rd == bus.in_rs1);
    assign mwb1 = use1 && wb_v && (wb_rd == bus.in_rs1);
    assign mex2 = use2 && ex_v && (ex_rd == bus.in_rs2);
    assign mwb2 = use2 && wb_v && (wb_rd == bus.in_rs2);

    assign hazard = haz_of(mex1, mwb1) || haz_of(mex2, mwb2);
    assign sel1   = sel_of(mex1, mwb1);
    assign sel2   = sel_of(mex2, mwb2);

    assign ready = (state == RUN) && !bus.halt_req && !hazard && rst;
    assign issue = bus.in_valid && ready;

    assign bus.in_ready  = ready;
    assign bus.iss_valid = issue;
    assign bus.iss_op    = issue ? bus.in_op  : 3'd0;
    assign bus.iss_rd    = issue ? bus.in_rd  : 3'd0;
    assign bus.iss_rs1   = issue ? bus.in_rs1 : 3'd0;
    assign bus.iss_rs2   = issue ? bus.in_rs2 : 3'd0;
    assign bus.fwd_sel1  = issue ? sel1 : 2'd0;
    assign bus.fwd_sel2  = issue ? sel2 : 2'd0;
    assign bus.halted    = (state == HALTED);
    assign bus.issue_cnt = issue_cnt_q;
    assign bus.stall_cnt = stall_cnt_q;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (bus.halt_req) state_nxt = DRAIN;
            DRAIN:   if (!ex_v && !wb_v) state_nxt = HALTED;
                     else if (!bus.halt_req) state_nxt = RUN;
            HALTED:  if (!bus.halt_req) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            ex_v        <= 1'b0;
            wb_v        <= 1'b0;
            ex_rd       <= 3'd0;
            wb_rd       <= 3'd0;
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            wb_v  <= ex_v;
            wb_rd <= ex_rd;
            ex_v  <= issue;
            if (issue)
                ex_rd <= bus.in_rd;
            if (issue)
                issue_cnt_q <= issue_cnt_q + 1'b1;
            if (state == RUN && bus.in_valid && !ready)
                stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Scoreboard bench: one controller per FWD_MODE, directed instruction pairs,
// halt/drain and mid-drain reset; a per-instance monitor checks every issue.
module tb_pipeline_issue_ctrl;
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic [1:0] f1;
        logic [1:0] f2;
    } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        in_valid [3];
    logic [2:0]  in_op    [3];
    logic [2:0]  in_rd    [3];
    logic [2:0]  in_rs1   [3];
    logic [2:0]  in_rs2   [3];
    logic        halt_req [3];
    logic        rdy      [3];
    logic        hlt      [3];
    logic        ivld     [3];
    logic [31:0] icnt     [3];
    logic [31:0] scnt     [3];

    iss_t exp_q [3][$];
    int   exp_issue [3];
    int   exp_stall [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        pipeline_issue_ctrl_if #(.CNT_W(32)) bus ();

        pipeline_issue_ctrl #(.FWD_MODE(g), .CNT_W(32)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.in_valid = in_valid[g];
        assign bus.in_op    = in_op[g];
        assign bus.in_rd    = in_rd[g];
        assign bus.in_rs1   = in_rs1[g];
        assign bus.in_rs2   = in_rs2[g];
        assign bus.halt_req = halt_req[g];
        assign rdy[g]       = bus.in_ready;
        assign hlt[g]       = bus.halted;
        assign ivld[g]      = bus.iss_valid;
        assign icnt[g]      = bus.issue_cnt;
        assign scnt[g]      = bus.stall_cnt;

        always @(negedge clk) begin
            iss_t e;
            if (rst) begin
                if (bus.iss_valid) begin
                    if (exp_q[g].size() == 0) begin
                        chk($sformatf("unexpected_issue_dut%0d", g), 32'd1, 32'd0);
                    end else begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("iss_dut%0d", g),
                            {16'd0, bus.iss_op, bus.iss_rd, bus.iss_rs1, bus.iss_rs2,
                             bus.fwd_sel1, bus.fwd_sel2}, {16'd0, e});
                    end
                end else begin
                    chk($sformatf("idle_zero_dut%0d", g),
                        {16'd0, bus.iss_op, bus.iss_rd, bus.iss_rs1, bus.iss_rs2,
                         bus.fwd_sel1, bus.fwd_sel2}, 32'd0);
                end
            end
        end
    end

    task automatic send(input int d, input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [1:0] f1, input logic [1:0] f2, input int stalls);
        int n = 0;
        exp_q[d].push_back(iss_t'({op, rd, rs1, rs2, f1, f2}));
        in_valid[d] = 1'b1;
        in_op[d]    = op;
        in_rd[d]    = rd;
        in_rs1[d]   = rs1;
        in_rs2[d]   = rs2;
        @(negedge clk);
        while (!rdy[d] && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("stalls_dut%0d", d), n, stalls);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_op[d]    = 3'd0;
        in_rd[d]    = 3'd0;
        in_rs1[d]   = 3'd0;
        in_rs2[d]   = 3'd0;
        exp_issue[d]++;
        exp_stall[d] += stalls;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input int d);
        chk($sformatf("issue_cnt_dut%0d", d), icnt[d], exp_issue[d]);
        chk($sformatf("stall_cnt_dut%0d", d), scnt[d], exp_stall[d]);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; in_op[i] = 3'd0; in_rd[i] = 3'd0;
            in_rs1[i] = 3'd0; in_rs2[i] = 3'd0; halt_req[i] = 1'b0;
            exp_issue[i] = 0; exp_stall[i] = 0;
        end
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_ready_dut%0d", i), {31'd0, rdy[i]}, 32'd0);
            chk($sformatf("rst_halted_dut%0d", i), {31'd0, hlt[i]}, 32'd0);
            chk($sformatf("rst_issue_cnt_dut%0d", i), icnt[i], 32'd0);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // No forwarding: dependent SUB waits for the regfile; immediate never stalls
        send(0, 3'd0, 3'd1, 3'd2, 3'd3, 2'd0, 2'd0, 0);
        send(0, 3'd1, 3'd4, 3'd1, 3'd1, 2'd0, 2'd0, 2);
        send(0, 3'd7, 3'd1, 3'd1, 3'd1, 2'd0, 2'd0, 0);
        chk_cnt(0);

        // WB forwarding only
        send(1, 3'd0, 3'd1, 3'd2, 3'd3, 2'd0, 2'd0, 0);
        send(1, 3'd1, 3'd4, 3'd1, 3'd1, 2'd2, 2'd2, 1);
        chk_cnt(1);

        // Full forwarding
        send(2, 3'd0, 3'd1, 3'd2, 3'd3, 2'd0, 2'd0, 0);
        send(2, 3'd1, 3'd4, 3'd1, 3'd1, 2'd1, 2'd1, 0);
        chk_cnt(2);
        idle(3);
        send(2, 3'd0, 3'd5, 3'd2, 3'd3, 2'd0, 2'd0, 0);
        send(2, 3'd0, 3'd5, 3'd2, 3'd3, 2'd0, 2'd0, 0);
        send(2, 3'd1, 3'd6, 3'd5, 3'd2, 2'd1, 2'd0, 0);
        idle(3);
        send(2, 3'd0, 3'd3, 3'd1, 3'd1, 2'd0, 2'd0, 0);
        idle(1);
        send(2, 3'd0, 3'd4, 3'd3, 3'd7, 2'd2, 2'd0, 0);
        send(2, 3'd7, 3'd2, 3'd4, 3'd4, 2'd0, 2'd0, 0);

        // Halt right after two issues, then resume
        send(2, 3'd0, 3'd1, 3'd0, 3'd0, 2'd0, 2'd0, 0);
        send(2, 3'd0, 3'd2, 3'd1, 3'd0, 2'd1, 2'd0, 0);
        halt_req[2] = 1'b1;
        @(negedge clk);
        chk("halt_ready_low", {31'd0, rdy[2]}, 32'd0);
        @(negedge clk);
        chk("drain_not_halted", {31'd0, hlt[2]}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("halted", {31'd0, hlt[2]}, 32'd1);
        halt_req[2] = 1'b0;
        @(negedge clk);
        chk("resume_ready", {31'd0, rdy[2]}, 32'd1);
        chk("resume_halted", {31'd0, hlt[2]}, 32'd0);
        @(posedge clk);
        #1;
        send(2, 3'd0, 3'd3, 3'd3, 3'd3, 2'd0, 2'd0, 0);
        chk_cnt(2);

        // Reset while draining clears everything without a clock edge
        idle(3);
        send(2, 3'd0, 3'd2, 3'd3, 3'd3, 2'd0, 2'd0, 0);
        halt_req[2] = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, rdy[2]}, 32'd0);
        chk("mid_rst_iss_valid", {31'd0, ivld[2]}, 32'd0);
        chk("mid_rst_halted", {31'd0, hlt[2]}, 32'd0);
        chk("mid_rst_issue_cnt", icnt[2], 32'd0);
        chk("mid_rst_stall_cnt", scnt[2], 32'd0);
        chk("mid_rst_issue_cnt_dut0", icnt[0], 32'd0);
        halt_req[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_issue[i] = 0;
            exp_stall[i] = 0;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        send(2, 3'd0, 3'd3, 3'd2, 3'd2, 2'd0, 2'd0, 0);
        chk_cnt(2);

        idle(2);
        for (int i = 0; i < 3; i++)
            chk($sformatf("queue_empty_dut%0d", i), exp_q[i].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
